unsigned_approx_mult_pipe: RTL and testbench

Parametrised, pipelined unsigned N x N multiplier with a per-transaction accuracy mode: exact, low-operand truncation, or truncation with high-column compensation. It generalises the fixed 8x8 level-4 combinational approximate multipliers to arbitrary width N and truncation level L. It adds a valid/ready stream interface, configurable pipeline depth, and an exact-error side output for on-line accuracy characterisation. It sits between operand producers and accumulators in the approximate-datapath test fabric.

---
 rtl/unsigned_approx_mult_pipe.sv | 106 ++++++++++
 tb/tb_unsigned_approx_mult_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_approx_mult_pipe.sv
// Pipelined unsigned N x N multiplier with a per-beat accuracy mode: exact,
// low-operand truncation, or truncation plus high-column compensation.
module unsigned_approx_mult_pipe #(
  parameter int N    = 8,
  parameter int L    = 4,
  parameter int PIPE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   z,
  output logic [2*N-1:0]   err,
  output logic [1:0]       out_mode
);

  localparam int W = 2 * N;

  logic [W-1:0]    x_w;
  logic [W-1:0]    y_w;
  logic [W-1:0]    p_in;
  logic [W-1:0]    trunc_in;
  logic [W-1:0]    comp_in;
  logic [W-1:0]    z_in;
  logic            advance;

  logic [PIPE-1:0] valid_q;
  logic [PIPE-1:0] valid_d;
  logic [W-1:0]    p_q    [PIPE];
  logic [W-1:0]    p_d    [PIPE];
  logic [W-1:0]    z_q    [PIPE];
  logic [W-1:0]    z_d    [PIPE];
  logic [1:0]      mode_q [PIPE];
  logic [1:0]      mode_d [PIPE];

  // Stage-1 arithmetic: exact product, truncated product and the compensation
  // term that restores dropped partial-product bits landing in columns >= N.
  always_comb begin
    x_w      = W'(x);
    y_w      = W'(y);
    p_in     = x_w * y_w;
    trunc_in = ((x_w >> L) * y_w) << L;
    comp_in  = '0;
    for (int i = 1; i < L; i++) begin
      if (x[i]) begin
        comp_in = comp_in + ((y_w & ~((W'(1) << (N - i)) - W'(1))) << i);
      end
    end
    case (mode)
      2'b01:   z_in = trunc_in;
      2'b10:   z_in = trunc_in + comp_in;
      default: z_in = p_in;
    endcase
  end

  assign advance  = !valid_q[PIPE-1] || out_ready;
  assign in_ready = advance || rst;

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_comb begin
    valid_d = valid_q;
    p_d     = p_q;
    z_d     = z_q;
    mode_d  = mode_q;
    if (advance) begin
      valid_d[0] = in_valid;
      p_d[0]     = p_in;
      z_d[0]     = z_in;
      mode_d[0]  = mode;
      for (int s = 1; s < PIPE; s++) begin
        valid_d[s] = valid_q[s-1];
        p_d[s]     = p_q[s-1];
        z_d[s]     = z_q[s-1];
        mode_d[s]  = mode_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < PIPE; s++) begin
        p_q[s]    <= '0;
        z_q[s]    <= '0;
        mode_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      p_q     <= p_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
    end
  end

  // The error is formed from the final stage so it always matches z.
  assign out_valid = valid_q[PIPE-1];
  assign z         = z_q[PIPE-1];
  assign err       = p_q[PIPE-1] - z_q[PIPE-1];
  assign out_mode  = mode_q[PIPE-1];

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Scoreboard bench for unsigned_approx_mult_pipe: an 8-bit instance for directed,
// stall and reset scenarios plus a 12-bit instance for a random sweep.
module tb_unsigned_approx_mult_pipe;

  localparam int N     = 8;
  localparam int L     = 4;
  localparam int PIPE  = 2;
  localparam int N2    = 12;
  localparam int L2    = 5;
  localparam int PIPE2 = 3;

  typedef struct {
    longint     z;
    longint     e;
    logic [1:0] m;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]    x, y;
  logic [1:0]      mode, out_mode;
  logic [2*N-1:0]  z, err;

  logic            in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [N2-1:0]   x_b, y_b;
  logic [1:0]      mode_b, out_mode_b;
  logic [2*N2-1:0] z_b, err_b;

  exp_t q8[$];
  exp_t q12[$];
  int   checks   = 0;
  int   failures = 0;
  logic sweep_done = 1'b0;

  unsigned_approx_mult_pipe #(.N(N), .L(L), .PIPE(PIPE)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .err(err), .out_mode(out_mode)
  );

  unsigned_approx_mult_pipe #(.N(N2), .L(L2), .PIPE(PIPE2)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .x(x_b), .y(y_b), .mode(mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .z(z_b), .err(err_b), .out_mode(out_mode_b)
  );

  // Reference: sum the partial-product matrix bit by bit, keeping x[i]y[j]
  // when its row survives truncation or, with compensation, its column >= n.
  function automatic exp_t refModel(input longint xv, input longint yv,
                                    input int n, input int l, input logic [1:0] m);
    exp_t   r;
    longint p    = 0;
    longint keep = 0;
    longint pp;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        if (xv[i] && yv[j]) begin
          pp = longint'(1) << (i + j);
          p  = p + pp;
          if (m == 2'b00 || m == 2'b11 || i >= l || (m == 2'b10 && i + j >= n))
            keep = keep + pp;
        end
      end
    end
    r.z = keep;
    r.e = p - keep;
    r.m = m;
    return r;
  endfunction

  function automatic exp_t mk(input longint zv, input longint ev, input logic [1:0] m);
    exp_t r;
    r.z = zv;
    r.e = ev;
    r.m = m;
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic applyStimulus(input logic [N-1:0] xv, input logic [N-1:0] yv,
                               input logic [1:0] m, input exp_t e);
    logic rdy;
    int   w = 0;
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    mode     = m;
    forever begin
      @(negedge clk);
      rdy = in_ready && !rst;
      @(posedge clk);
      if (rdy) begin
        q8.push_back(e);
        break;
      end
      w++;
      if (w > 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout actual=not_accepted expected=accepted");
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyRandom(input int k);
    logic [N-1:0] xv, yv;
    logic [1:0]   m;
    xv = (k % 13 == 0) ? '0 : N'($urandom);
    yv = (k % 17 == 0) ? '0 : N'($urandom);
    m  = 2'($urandom_range(3));
    applyStimulus(xv, yv, m, refModel(longint'(xv), longint'(yv), N, L, m));
  endtask

  task automatic drain();
    int w = 0;
    while ((q8.size() != 0 || q12.size() != 0) && w < 300) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain8_left", q8.size(), 0);
    checkOutput("drain12_left", q12.size(), 0);
  endtask

  // Monitor for the 8-bit instance: pops on each handshake and checks that a
  // stalled beat stays frozen with in_ready low.
  initial begin : mon8
    logic           held;
    logic [2*N-1:0] hz, he;
    logic [1:0]     hm;
    exp_t           e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_z", z, hz);
        checkOutput("stall_err", err, he);
        checkOutput("stall_mode", out_mode, hm);
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", in_ready, 0);
        held = 1'b1;
        hz   = z;
        he   = err;
        hm   = out_mode;
      end else if (out_valid && out_ready) begin
        if (q8.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_out8 actual=z:%0h expected=no_output", z);
        end else begin
          e = q8.pop_front();
          checkOutput("z8", z, e.z);
          checkOutput("err8", err, e.e);
          checkOutput("mode8", out_mode, e.m);
        end
      end
    end
  end

  initial begin : mon12
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_b && out_ready_b) begin
        if (q12.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_out12 actual=z:%0h expected=no_output", z_b);
        end else begin
          e = q12.pop_front();
          checkOutput("z12", z_b, e.z);
          checkOutput("err12", err_b, e.e);
          checkOutput("mode12", out_mode_b, e.m);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int k;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; mode = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b1; x_b = '0; y_b = '0; mode_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_z", z, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_out_mode", out_mode, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid12", out_valid_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed accuracy-mode beats");
    applyStimulus(8'hFF, 8'hFF, 2'b00, mk(16'hFE01, 16'h0000, 2'b00));
    applyStimulus(8'hFF, 8'hFF, 2'b01, mk(16'hEF10, 16'h0EF1, 2'b01));
    applyStimulus(8'hFF, 8'hFF, 2'b10, mk(16'hFA10, 16'h03F1, 2'b10));
    applyStimulus(8'h0F, 8'hFF, 2'b01, mk(16'h0000, 16'h0EF1, 2'b01));
    applyStimulus(8'h0F, 8'hFF, 2'b10, mk(16'h0B00, 16'h03F1, 2'b10));
    applyStimulus(8'h10, 8'h03, 2'b10, mk(16'h0030, 16'h0000, 2'b10));
    applyStimulus(8'h10, 8'h03, 2'b11, mk(16'h0030, 16'h0000, 2'b11));
    drain();

    $display("[TB] latency of an isolated beat");
    applyStimulus(8'h21, 8'h04, 2'b00, mk(16'h0084, 16'h0000, 2'b00));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    checkOutput("latency", k, PIPE);
    drain();

    $display("[TB] backpressure stream");
    fork
      begin
        for (int v = 1; v <= 5; v++)
          applyStimulus(N'(v), 8'd3, 2'b00, mk(longint'(3 * v), 0, 2'b00));
      end
      begin
        int w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!out_valid && w < 50);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] reset with beats in flight");
    out_ready = 1'b0;
    applyStimulus(8'h11, 8'h02, 2'b00, mk(16'h0022, 0, 2'b00));
    applyStimulus(8'h12, 8'h02, 2'b01, mk(16'h0020, 16'h0004, 2'b01));
    rst = 1'b1;
    in_valid = 1'b1; x = 8'h55; y = 8'h02; mode = 2'b00;
    @(negedge clk);
    checkOutput("in_ready_during_rst", in_ready, 1);
    @(posedge clk);
    q8.delete();
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_z", z, 0);
    checkOutput("post_rst_err", err, 0);
    checkOutput("post_rst_mode", out_mode, 0);
    @(posedge clk);
    #1;
    applyStimulus(8'h07, 8'h09, 2'b00, mk(16'h003F, 0, 2'b00));
    drain();

    $display("[TB] randomised sweeps");
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            applyRandom(i);
          end
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
      begin
        logic acc;
        for (int i = 0; i < 400; i++) begin
          in_valid_b  = ($urandom_range(3) != 0);
          x_b         = (i % 23 == 0) ? '0 : N2'($urandom);
          y_b         = (i % 29 == 0) ? '0 : N2'($urandom);
          mode_b      = 2'($urandom_range(3));
          out_ready_b = ($urandom_range(4) != 0);
          @(negedge clk);
          acc = in_valid_b && in_ready_b;
          @(posedge clk);
          if (acc)
            q12.push_back(refModel(longint'(x_b), longint'(y_b), N2, L2, mode_b));
          #1;
        end
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
